// File: rtl/conv_layer_sequencer_if.sv
// Control bus between a conv-layer sequencer and its MAC datapath / stream sources.
// Widths are derived from the layer geometry so both ends always agree.
interface conv_layer_sequencer_if #(
   parameter int WOUT       = 64,
   parameter int CHIN       = 64,
   parameter int KERNEL_DIM = 3
);
   localparam int MACS      = KERNEL_DIM * KERNEL_DIM * CHIN;
   localparam int PIX_TOTAL = WOUT * WOUT;
   localparam int AW        = (MACS > 1) ? $clog2(MACS) : 1;
   localparam int PW        = $clog2(PIX_TOTAL + 1);

   logic          start;
   logic          ifm_valid;
   logic          ofm_ready;
   logic [AW-1:0] weight_addr;
   logic          mac_en;
   logic          mac_clr;
   logic          ofm_sample;
   logic [PW-1:0] pix_count;
   logic          busy;
   logic          done;

   // Layer controller / stream side: launches the layer and supplies handshakes.
   modport master (
      output start, ifm_valid, ofm_ready,
      input  weight_addr, mac_en, mac_clr, ofm_sample, pix_count, busy, done
   );

   // Sequencer side.
   modport slave (
      input  start, ifm_valid, ofm_ready,
      output weight_addr, mac_en, mac_clr, ofm_sample, pix_count, busy, done
   );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Per-layer control FSM for a bank of parallel MACs sharing one ifm stream.
// Walks the weight ROM per output pixel, drains the ROM/kernel-register pipeline,
// then emits one clear/sample pulse when the output RAM is ready.
module conv_layer_sequencer #(
   parameter int WOUT       = 64,
   parameter int CHIN       = 64,
   parameter int KERNEL_DIM = 3,
   parameter int PIPE_LAT   = 2
) (
   input logic                    clk,
   input logic                    rst,
   conv_layer_sequencer_if.slave  ctl
);
   localparam int MACS      = KERNEL_DIM * KERNEL_DIM * CHIN;
   localparam int PIX_TOTAL = WOUT * WOUT;
   localparam int AW        = (MACS > 1) ? $clog2(MACS) : 1;
   localparam int PW        = $clog2(PIX_TOTAL + 1);
   localparam int FW        = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [AW-1:0] ADDR_LAST  = AW'(MACS - 1);
   localparam logic [PW-1:0] PIX_LAST   = PW'(PIX_TOTAL - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_FLUSH,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [AW-1:0] weight_addr_q;
   logic [PW-1:0] pix_count_q;
   logic [FW-1:0] flush_q;
   logic          accum_q;
   logic          sample_q;
   logic          busy_q;
   logic          done_q;

   logic          mac_en_d;
   logic          pulse_d;

   // Only the two handshake gates look at inputs; everything else comes from registers.
   // The sample pulse is gated by ofm_ready in the same cycle so a stalled RAM never
   // sees a capture and the accumulators simply hold.
   assign mac_en_d = accum_q  & ctl.ifm_valid;
   assign pulse_d  = sample_q & ctl.ofm_ready;

   // Sequencer FSM: state, counters and decoded status flags updated together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         weight_addr_q <= '0;
         pix_count_q   <= '0;
         flush_q       <= '0;
         accum_q       <= 1'b0;
         sample_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (ctl.start) begin
                  state_q       <= S_ACCUM;
                  weight_addr_q <= '0;
                  pix_count_q   <= '0;
                  flush_q       <= '0;
                  accum_q       <= 1'b1;
                  busy_q        <= 1'b1;
                  done_q        <= 1'b0;
               end
            end
            S_ACCUM: begin
               if (mac_en_d) begin
                  if (weight_addr_q == ADDR_LAST) begin
                     weight_addr_q <= '0;
                     state_q       <= S_FLUSH;
                     accum_q       <= 1'b0;
                  end else begin
                     weight_addr_q <= weight_addr_q + 1'b1;
                  end
               end
            end
            S_FLUSH: begin
               if (flush_q == FLUSH_LAST) begin
                  flush_q  <= '0;
                  state_q  <= S_SAMPLE;
                  sample_q <= 1'b1;
               end else begin
                  flush_q <= flush_q + 1'b1;
               end
            end
            S_SAMPLE: begin
               if (pulse_d) begin
                  pix_count_q <= pix_count_q + 1'b1;
                  sample_q    <= 1'b0;
                  if (pix_count_q == PIX_LAST) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ACCUM;
                     accum_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q  <= S_IDLE;
               accum_q  <= 1'b0;
               sample_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ctl.weight_addr = weight_addr_q;
   assign ctl.mac_en      = mac_en_d;
   assign ctl.mac_clr     = pulse_d;
   assign ctl.ofm_sample  = pulse_d;
   assign ctl.pix_count   = pix_count_q;
   assign ctl.busy        = busy_q;
   assign ctl.done        = done_q;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer on a tiny layer (MACS=4, PIX_TOTAL=4, PIPE_LAT=2).
module tb_conv_layer_sequencer;
   localparam int WOUT       = 2;
   localparam int CHIN       = 1;
   localparam int KERNEL_DIM = 2;
   localparam int PIPE_LAT   = 2;
   localparam int MACS       = 4;

   logic clk;
   logic rst;

   conv_layer_sequencer_if #(.WOUT(WOUT), .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM)) sif ();

   conv_layer_sequencer #(
      .WOUT(WOUT), .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ctl (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int inv_err = 0;
   int mac_since = 0;

   // Per-run stimulus masks, bit c applies to cycle c of the run.
   logic [63:0] st_v, iv_v, rd_v, rl_v;

   // Per-run observations.
   int mac_cyc[$];
   int mac_addr[$];
   int smp_cyc[$];
   int done_cyc;
   int addr_v[64];
   int pix_v[64];
   int busy_v[64];
   int done_v[64];

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // Drive one cycle of inputs, observe outputs mid-cycle, advance past the edge.
   task automatic step(input int c, input logic s, input logic iv, input logic rd, input logic r);
      rst           = r;
      sif.start     = s;
      sif.ifm_valid = iv;
      sif.ofm_ready = rd;
      @(negedge clk);
      if (sif.mac_en) begin
         mac_cyc.push_back(c);
         mac_addr.push_back(int'(sif.weight_addr));
      end
      if (sif.ofm_sample) smp_cyc.push_back(c);
      if (sif.done && done_cyc < 0) done_cyc = c;
      addr_v[c] = int'(sif.weight_addr);
      pix_v[c]  = int'(sif.pix_count);
      busy_v[c] = int'(sif.busy);
      done_v[c] = int'(sif.done);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int ncyc);
      mac_cyc.delete();
      mac_addr.delete();
      smp_cyc.delete();
      done_cyc = -1;
      for (int c = 0; c < ncyc; c++)
         step(c, st_v[c], iv_v[c], rd_v[c], ~rl_v[c]);
   endtask

   task automatic do_reset();
      for (int c = 0; c < 2; c++) step(c, 1'b0, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
   endtask

   // Invariant monitor: pulses coincide, address in range, MACs only when busy and fed,
   // and exactly MACS consumptions between consecutive samples.
   always @(negedge clk) begin
      if (!rst) begin
         mac_since = 0;
      end else begin
         if (sif.mac_clr != sif.ofm_sample) inv_err++;
         if (int'(sif.weight_addr) >= MACS) inv_err++;
         if (sif.mac_en && (!sif.busy || !sif.ifm_valid)) inv_err++;
         if (sif.mac_en) begin
            if (mac_since >= MACS) inv_err++;
            mac_since++;
         end
         if (sif.ofm_sample) begin
            if (mac_since != MACS) inv_err++;
            mac_since = 0;
         end
      end
   end

   initial begin
      rst = 1'b0;
      sif.start = 1'b0;
      sif.ifm_valid = 1'b1;
      sif.ofm_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset state, with handshakes asserted to show they are ignored.
      step(0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("rst_addr", int'(sif.weight_addr), 0);
      chk("rst_pix", int'(sif.pix_count), 0);
      chk("rst_busy", int'(sif.busy), 0);
      chk("rst_done", int'(sif.done), 0);
      chk("rst_mac_en", int'(sif.mac_en), 0);
      chk("rst_mac_clr", int'(sif.mac_clr), 0);
      chk("rst_sample", int'(sif.ofm_sample), 0);
      rst = 1'b1;

      // Full layer, no stalls.
      st_v = 64'h1; iv_v = '1; rd_v = '1; rl_v = '0;
      run(32);
      chk("t1_mac_total", mac_cyc.size(), 16);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_mac_cyc%0d", i), qget(mac_cyc, i), i + 1);
         chk($sformatf("t1_mac_addr%0d", i), qget(mac_addr, i), i);
      end
      chk("t1_smp_total", smp_cyc.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t1_smp%0d", i), qget(smp_cyc, i), 7 + 7 * i);
      chk("t1_pix_c7", pix_v[7], 0);
      chk("t1_pix_c8", pix_v[8], 1);
      chk("t1_done_cyc", done_cyc, 29);
      chk("t1_pix_final", pix_v[31], 4);
      chk("t1_busy_final", busy_v[31], 0);

      // Relaunch from DONE, and a start during ACCUM that must be ignored.
      st_v = 64'h0; st_v[0] = 1'b1; st_v[2] = 1'b1; st_v[9] = 1'b1;
      run(11);
      chk("t4_done_c0", done_v[0], 1);
      chk("t4_pix_c0", pix_v[0], 4);
      chk("t4_pix_c1", pix_v[1], 0);
      chk("t4_done_c1", done_v[1], 0);
      chk("t4_busy_c1", busy_v[1], 1);
      chk("t4_addr_c3", addr_v[3], 2);
      chk("t4_smp", qget(smp_cyc, 0), 7);
      chk("t4_pix_c10", pix_v[10], 1);
      chk("t4_addr_c10", addr_v[10], 2);
      chk("t4_mac_total", mac_cyc.size(), 7);
      do_reset();

      // ifm_valid gap in pixel 0.
      st_v = 64'h1; iv_v = '1; iv_v[2] = 1'b0; iv_v[3] = 1'b0;
      run(10);
      chk("t2_mac_total", mac_cyc.size(), 4);
      chk("t2_mac1_cyc", qget(mac_cyc, 1), 4);
      chk("t2_mac3_cyc", qget(mac_cyc, 3), 6);
      chk("t2_mac3_addr", qget(mac_addr, 3), 3);
      chk("t2_addr_c2", addr_v[2], 1);
      chk("t2_addr_c3", addr_v[3], 1);
      chk("t2_smp", qget(smp_cyc, 0), 9);
      do_reset();

      // Output RAM backpressure during SAMPLE.
      st_v = 64'h1; iv_v = '1; rd_v = '1; rd_v[7] = 1'b0; rd_v[8] = 1'b0; rd_v[9] = 1'b0;
      run(12);
      chk("t3_smp_total", smp_cyc.size(), 1);
      chk("t3_smp", qget(smp_cyc, 0), 10);
      chk("t3_pix_c10", pix_v[10], 0);
      chk("t3_pix_c11", pix_v[11], 1);
      chk("t3_next_mac", qget(mac_cyc, 4), 11);
      do_reset();

      // Asynchronous reset while in FLUSH, then a clean relaunch.
      st_v = 64'h0; st_v[0] = 1'b1; st_v[7] = 1'b1; rd_v = '1; rl_v = '0; rl_v[5] = 1'b1;
      run(16);
      chk("t5_busy_c5", busy_v[5], 0);
      chk("t5_addr_c5", addr_v[5], 0);
      chk("t5_pix_c5", pix_v[5], 0);
      chk("t5_busy_c6", busy_v[6], 0);
      chk("t5_smp_total", smp_cyc.size(), 1);
      chk("t5_smp", qget(smp_cyc, 0), 14);
      chk("t5_relaunch_mac", qget(mac_cyc, 4), 8);
      chk("t5_relaunch_addr", qget(mac_addr, 4), 0);

      chk("invariants", inv_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
